uart_tx: RTL and testbench

//  UART transmitter; the transmit-side counterpart of uart_rx in the UART sim model.

---
 rtl/uart_tx.sv | 118 +++++++++++
 tb/tb_uart_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, PAYLOAD_BITS data bits LSB first, STOP_BITS stop bits.
// A valid/busy handshake on the user side; the serial line is registered and idles high.
module uart_tx #(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_MHZ      = 50,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    output logic                    uart_txd,
    output logic                    uart_tx_busy,
    output logic                    uart_tx_done
);

    localparam int BIT_P          = 1_000_000_000 / BIT_RATE;
    localparam int CLK_P          = 1000 / CLK_MHZ;
    localparam int CYCLES_PER_BIT = BIT_P / CLK_P;

    localparam logic [15:0] CPB_LAST  = 16'(CYCLES_PER_BIT - 1);
    localparam logic [3:0]  DATA_LAST = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, SEND, STOP} state_t;

    state_t                  state, state_nxt;
    logic [15:0]             cycle_counter, cycle_counter_nxt;
    logic [3:0]              bit_counter, bit_counter_nxt;
    logic [PAYLOAD_BITS-1:0] shift, shift_nxt;
    logic                    txd_nxt;
    logic                    done_nxt;
    logic                    bit_end;

    assign bit_end      = (cycle_counter == CPB_LAST);
    assign uart_tx_busy = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            cycle_counter <= '0;
            bit_counter   <= '0;
            shift         <= '0;
            uart_txd      <= 1'b1;
            uart_tx_done  <= 1'b0;
        end else begin
            state         <= state_nxt;
            cycle_counter <= cycle_counter_nxt;
            bit_counter   <= bit_counter_nxt;
            shift         <= shift_nxt;
            uart_txd      <= txd_nxt;
            uart_tx_done  <= done_nxt;
        end
    end

    // txd is computed one edge ahead so the line changes exactly on bit boundaries.
    always_comb begin
        state_nxt         = state;
        cycle_counter_nxt = cycle_counter + 16'd1;
        bit_counter_nxt   = bit_counter;
        shift_nxt         = shift;
        txd_nxt           = uart_txd;
        done_nxt          = 1'b0;
        case (state)
            IDLE: begin
                cycle_counter_nxt = '0;
                bit_counter_nxt   = '0;
                txd_nxt           = 1'b1;
                if (uart_tx_en) begin
                    shift_nxt = uart_tx_data;
                    state_nxt = START;
                    txd_nxt   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    cycle_counter_nxt = '0;
                    state_nxt         = SEND;
                    txd_nxt           = shift[0];
                end
            end
            SEND: begin
                if (bit_end) begin
                    cycle_counter_nxt = '0;
                    if (bit_counter == DATA_LAST) begin
                        bit_counter_nxt = '0;
                        state_nxt       = STOP;
                        txd_nxt         = 1'b1;
                    end else begin
                        bit_counter_nxt = bit_counter + 4'd1;
                        shift_nxt       = shift >> 1;
                        txd_nxt         = shift_nxt[0];
                    end
                end
            end
            STOP: begin
                txd_nxt = 1'b1;
                // bit_counter is reused to count stop bits so cycle_counter never exceeds one bit.
                if (bit_end) begin
                    cycle_counter_nxt = '0;
                    if (bit_counter == STOP_LAST) begin
                        bit_counter_nxt = '0;
                        state_nxt       = IDLE;
                        done_nxt        = 1'b1;
                    end else begin
                        bit_counter_nxt = bit_counter + 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                txd_nxt   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed cycle checks on an 8N1 instance plus serial-line
// decoders feeding a scoreboard for 8N1 and 8N2 instances.
module tb_uart_tx;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       resetn;
    logic       en1, en2;
    logic [7:0] data1, data2;
    logic       txd1, busy1, done1;
    logic       txd2, busy2, done2;
    logic       mon1_en, mon2_en;

    logic [7:0] q1[$];
    logic [7:0] q2[$];

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    uart_tx #(.BIT_RATE(5_000_000), .CLK_MHZ(50), .PAYLOAD_BITS(8), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .uart_tx_en(en1), .uart_tx_data(data1),
        .uart_txd(txd1), .uart_tx_busy(busy1), .uart_tx_done(done1)
    );

    uart_tx #(.BIT_RATE(5_000_000), .CLK_MHZ(50), .PAYLOAD_BITS(8), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .resetn(resetn), .uart_tx_en(en2), .uart_tx_data(data2),
        .uart_txd(txd2), .uart_tx_busy(busy2), .uart_tx_done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic line(input bit which);
        return which ? txd2 : txd1;
    endfunction

    // Decoder entered on the first negedge the line is seen low; samples mid-bit.
    task automatic rx_frame(input bit which, input int sb);
        logic [7:0] d;
        logic [7:0] exp;
        int         sz;
        d = '0;
        repeat (CPB/2 - 1) @(negedge clk);
        chk(which ? "rx2_start" : "rx1_start", line(which), 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            d[i] = line(which);
        end
        for (int s = 0; s < sb; s++) begin
            repeat (CPB) @(negedge clk);
            chk(which ? "rx2_stop" : "rx1_stop", line(which), 1'b1);
        end
        sz = which ? q2.size() : q1.size();
        chk(which ? "rx2_expected_frame" : "rx1_expected_frame", sz != 0, 1'b1);
        if (sz != 0) begin
            if (which) exp = q2.pop_front();
            else       exp = q1.pop_front();
            chk(which ? "rx2_data" : "rx1_data", d, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon1_en && resetn === 1'b1 && txd1 === 1'b0) rx_frame(1'b0, 1);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon2_en && resetn === 1'b1 && txd2 === 1'b0) rx_frame(1'b1, 2);
        end
    end

    // Called one cycle after the accept edge; walks the 8N1 frame cycle by cycle.
    task automatic check_frame(input logic [7:0] d, input int pulse_at);
        logic [9:0] pat;
        pat = {1'b1, d, 1'b0};
        for (int k = 0; k < 10*CPB; k++) begin
            chk("frame_txd", txd1, pat[k/CPB]);
            chk("frame_busy", busy1, 1'b1);
            chk("frame_done", done1, 1'b0);
            if (pulse_at >= 0 && k == pulse_at) begin
                en1   = 1'b1;
                data1 = 8'h55;
            end else if (pulse_at >= 0 && k == pulse_at + 1) begin
                en1 = 1'b0;
            end
            tick();
        end
        chk("done_pulse", done1, 1'b1);
        chk("done_busy", busy1, 1'b0);
        chk("done_txd", txd1, 1'b1);
    endtask

    task automatic drive_rand(input bit which, input int n);
        int         w;
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while ((which ? busy2 : busy1) && w < 300) begin
                tick();
                w++;
            end
            chk(which ? "drv2_idle_timeout" : "drv1_idle_timeout", w < 300, 1'b1);
            repeat ($urandom_range(0, 2)) tick();
            b = 8'($urandom);
            if (which) begin q2.push_back(b); en2 = 1'b1; data2 = b; end
            else       begin q1.push_back(b); en1 = 1'b1; data1 = b; end
            tick();
            if (which) en2 = 1'b0;
            else       en1 = 1'b0;
        end
    endtask

    initial begin
        logic quiet;
        resetn = 1'b0; en1 = 1'b0; en2 = 1'b0; data1 = '0; data2 = '0;
        mon1_en = 1'b0; mon2_en = 1'b0;

        // Reset state, then a long idle stretch.
        repeat (3) tick();
        chk("rst_txd", txd1, 1'b1);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_done", done1, 1'b0);
        chk("rst_txd2", txd2, 1'b1);
        resetn = 1'b1;
        mon1_en = 1'b1; mon2_en = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (txd1 !== 1'b1 || busy1 !== 1'b0) quiet = 1'b0;
            tick();
        end
        chk("idle_line_high", quiet, 1'b1);

        // Single A5 frame with busy/done timing.
        en1 = 1'b1; data1 = 8'hA5; q1.push_back(8'hA5);
        tick();
        en1 = 1'b0;
        check_frame(8'hA5, -1);
        tick();
        chk("done_one_cycle", done1, 1'b0);
        repeat (5) tick();

        // en held high: back-to-back 00 then FF with one idle cycle between.
        en1 = 1'b1; data1 = 8'h00; q1.push_back(8'h00);
        tick();
        data1 = 8'hFF;
        check_frame(8'h00, -1);
        q1.push_back(8'hFF);
        tick();
        en1 = 1'b0;
        check_frame(8'hFF, -1);
        repeat (5) tick();

        // Request while busy is dropped.
        en1 = 1'b1; data1 = 8'h3C; q1.push_back(8'h3C);
        tick();
        en1 = 1'b0;
        check_frame(8'h3C, 29);
        quiet = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (busy1 !== 1'b0) quiet = 1'b0;
            tick();
        end
        chk("no_second_frame", quiet, 1'b1);

        // Reset mid-frame, then a clean frame.
        mon1_en = 1'b0;
        en1 = 1'b1; data1 = 8'hF0;
        tick();
        en1 = 1'b0;
        repeat (44) tick();
        resetn = 1'b0;
        #1;
        chk("midrst_txd", txd1, 1'b1);
        chk("midrst_busy", busy1, 1'b0);
        chk("midrst_done", done1, 1'b0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        chk("postrst_busy", busy1, 1'b0);
        chk("postrst_txd", txd1, 1'b1);
        mon1_en = 1'b1;
        en1 = 1'b1; data1 = 8'h96; q1.push_back(8'h96);
        tick();
        en1 = 1'b0;
        check_frame(8'h96, -1);

        // Random loopback through the decoders on both instances.
        fork
            drive_rand(1'b0, 256);
            drive_rand(1'b1, 256);
        join
        repeat (200) tick();
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
